prmcu_uart_rx: RTL and testbench

UART receiver: deserialises the asynchronous rx_i line into words and presents them on a valid/ready stream.
- Frame: start bit, 5-9 data bits LSB first, optional even-parity bit, 1-2 stop bits.
- Pairs with the existing UART transmitter inside prmcu_uart_top and shares its runtime configuration fields and bit-period rule: one bit = 2*internal_clk_divider clk cycles.
- Flags parity, framing and overrun errors per frame.

---
 rtl/prmcu_uart_pkg.sv | 30 +++
 rtl/prmcu_uart_sync.sv | 25 ++
 rtl/prmcu_uart_rx.sv | 143 ++++++++++++++
 tb/tb_prmcu_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prmcu_uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame limits and configuration clamping.
// Used by both the receiver and the transmitter inside prmcu_uart_top.
package prmcu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER
  } rx_state_e;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;
  localparam logic [3:0] MAX_DATA_BITS = 4'd9;

  // Out-of-range register values map onto the nearest legal frame format.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
    if (n < MIN_DATA_BITS) return MIN_DATA_BITS;
    if (n > MAX_DATA_BITS) return MAX_DATA_BITS;
    return n;
  endfunction

  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] n);
    if (n == 2'd0) return 2'd1;
    if (n == 2'd3) return 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/prmcu_uart_sync.sv
// N-flop metastability synchroniser with a configurable preset value.
// Shared by the UART receive line and the CTS/RTS handshake inputs.
module prmcu_uart_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {N{RESET_VAL}};
    end else begin
      stages <= (stages << 1) | N'(d);
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/prmcu_uart_rx.sv
// UART receiver: samples rx_i mid-bit at 2*divider clk cycles per bit and
// presents each frame with parity/framing flags on a single-entry valid/ready output.
module prmcu_uart_rx
  import prmcu_uart_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_en,
  input  logic              rx_en,
  input  logic              n_parity_bits,
  input  logic [1:0]        n_stop_bits,
  input  logic [3:0]        n_data_bits,
  input  logic [DIV_W-1:0]  internal_clk_divider,
  input  logic              rx_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  logic              rx_s;
  logic              rx_prev;
  logic              rx_en_q;
  logic              active;
  rx_state_e         state;
  logic [DIV_W:0]    timer;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  div_now;
  logic [DIV_W:0]    full_bit;
  logic [DIV_W:0]    half_bit;
  logic [3:0]        cfg_bits;
  logic              cfg_par;
  logic              cfg_two_stop;
  logic [3:0]        bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shift_q;
  logic              perr_q;
  logic              ferr_q;

  prmcu_uart_sync #(
    .N         (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign active   = uart_en & rx_en;
  assign div_now  = (internal_clk_divider == '0) ? DIV_W'(1) : internal_clk_divider;
  assign half_bit = {1'b0, div_now} - (DIV_W+1)'(1);
  assign full_bit = {cfg_div, 1'b0} - (DIV_W+1)'(1);

  // rx_prev tracks the line every cycle, so after a break the idle edge
  // detector only re-arms once the line has been seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rx_prev      <= 1'b1;
      rx_en_q      <= 1'b0;
      timer        <= '0;
      cfg_div      <= DIV_W'(1);
      cfg_bits     <= MIN_DATA_BITS;
      cfg_par      <= 1'b0;
      cfg_two_stop <= 1'b0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      out_dat_o    <= '0;
      out_vld_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      rx_en_q <= rx_en;
      if (rx_en & ~rx_en_q) overrun_o <= 1'b0;
      if (out_vld_o & out_rdy_i) out_vld_o <= 1'b0;

      if (!active) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (rx_prev & ~rx_s) begin
          cfg_div      <= div_now;
          cfg_bits     <= clamp_data_bits(n_data_bits);
          cfg_par      <= n_parity_bits;
          cfg_two_stop <= (clamp_stop_bits(n_stop_bits) == 2'd2);
          timer        <= half_bit;
          bit_idx      <= '0;
          stop_idx     <= 1'b0;
          shift_q      <= '0;
          perr_q       <= 1'b0;
          state        <= START;
        end
      end else if (state == DELIVER) begin
        if (!out_vld_o || out_rdy_i) begin
          out_dat_o    <= shift_q;
          parity_err_o <= perr_q;
          frame_err_o  <= ferr_q;
          out_vld_o    <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
        state <= IDLE;
      end else if (timer != '0) begin
        timer <= timer - (DIV_W+1)'(1);
      end else begin
        timer <= full_bit;
        case (state)
          START: begin
            state <= rx_s ? IDLE : DATA;
          end
          DATA: begin
            shift_q <= shift_q | (DATA_W'(rx_s) << bit_idx);
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == cfg_bits - 4'd1) state <= cfg_par ? PARITY : STOP;
          end
          PARITY: begin
            perr_q <= rx_s ^ (^shift_q);
            state  <= STOP;
          end
          STOP: begin
            // Only the first stop bit can flag a framing error.
            if (!stop_idx) ferr_q <= ~rx_s;
            if (cfg_two_stop && !stop_idx) stop_idx <= 1'b1;
            else                           state    <= DELIVER;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prmcu_uart_rx.sv
// Directed and randomized frames for prmcu_uart_rx, checked against a frame-level model.
module tb_prmcu_uart_rx;

  localparam int DATA_W      = 9;
  localparam int DIV_W       = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_en;
  logic              rx_en;
  logic              n_parity_bits;
  logic [1:0]        n_stop_bits;
  logic [3:0]        n_data_bits;
  logic [DIV_W-1:0]  internal_clk_divider;
  logic              rx_i;
  logic [DATA_W-1:0] out_dat_o;
  logic              out_vld_o;
  logic              out_rdy_i;
  logic              parity_err_o;
  logic              frame_err_o;
  logic              overrun_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_dat;
  logic       exp_perr;
  logic       exp_ferr;

  prmcu_uart_rx #(
    .DATA_W      (DATA_W),
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_en              (uart_en),
    .rx_en                (rx_en),
    .n_parity_bits        (n_parity_bits),
    .n_stop_bits          (n_stop_bits),
    .n_data_bits          (n_data_bits),
    .internal_clk_divider (internal_clk_divider),
    .rx_i                 (rx_i),
    .out_dat_o            (out_dat_o),
    .out_vld_o            (out_vld_o),
    .out_rdy_i            (out_rdy_i),
    .parity_err_o         (parity_err_o),
    .frame_err_o          (frame_err_o),
    .overrun_o            (overrun_o)
  );

  always #5 clk = ~clk;

  function automatic int effBits(input int raw);
    return (raw < 5) ? 5 : ((raw > 9) ? 9 : raw);
  endfunction

  function automatic int effStops(input int raw);
    return (raw == 0) ? 1 : ((raw == 3) ? 2 : raw);
  endfunction

  function automatic int effDiv();
    return (internal_clk_divider == 0) ? 1 : int'(internal_clk_divider);
  endfunction

  task automatic holdBits(input int nbits);
    repeat (nbits * 2 * effDiv()) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one serial frame and records the word/flags the receiver should report.
  task automatic applyStimulus(input logic [8:0] data, input int nb_raw, input bit par_en,
                               input bit par_flip, input int st_raw, input bit stop0,
                               input int abort_after);
    int         nb;
    logic [8:0] masked;
    logic       par;
    nb       = effBits(nb_raw);
    masked   = data & 9'((1 << nb) - 1);
    par      = (^masked) ^ par_flip;
    exp_dat  = masked;
    exp_perr = par_en & par_flip;
    exp_ferr = ~stop0;
    n_data_bits   = 4'(nb_raw);
    n_parity_bits = par_en;
    n_stop_bits   = 2'(st_raw);
    rx_i = 1'b0;
    holdBits(1);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_after) begin
        rx_en = 1'b0;
        rx_i  = 1'b1;
        repeat (10) @(negedge clk);
        rx_en = 1'b1;
        return;
      end
      rx_i = masked[i];
      holdBits(1);
    end
    if (par_en) begin
      rx_i = par;
      holdBits(1);
    end
    rx_i = stop0;
    holdBits(1);
    if (effStops(st_raw) == 2) begin
      rx_i = 1'b1;
      holdBits(1);
    end
    rx_i = 1'b1;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!out_vld_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(out_vld_o), 32'd1);
  endtask

  task automatic consume(input string tag);
    out_rdy_i = 1'b1;
    @(negedge clk);
    out_rdy_i = 1'b0;
    checkOutput(tag, 32'(out_vld_o), 32'd0);
  endtask

  task automatic checkFrame(input string tag);
    waitValid({tag, "_vld"});
    checkOutput({tag, "_dat"},  32'(out_dat_o),    32'(exp_dat));
    checkOutput({tag, "_perr"}, 32'(parity_err_o), 32'(exp_perr));
    checkOutput({tag, "_ferr"}, 32'(frame_err_o),  32'(exp_ferr));
    consume({tag, "_consume"});
  endtask

  initial begin
    rst = 1'b1;
    uart_en = 1'b1;
    rx_en = 1'b1;
    n_parity_bits = 1'b0;
    n_stop_bits = 2'd1;
    n_data_bits = 4'd8;
    internal_clk_divider = 8'd43;
    rx_i = 1'b1;
    out_rdy_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_dat",  32'(out_dat_o),    32'd0);
    checkOutput("rst_vld",  32'(out_vld_o),    32'd0);
    checkOutput("rst_perr", 32'(parity_err_o), 32'd0);
    checkOutput("rst_ferr", 32'(frame_err_o),  32'd0);
    checkOutput("rst_ovr",  32'(overrun_o),    32'd0);

    $display("[TB] 8N1 0xA5, held until ready");
    applyStimulus(9'h0A5, 8, 0, 0, 1, 1, -1);
    waitValid("a5_vld");
    repeat (20) @(negedge clk);
    checkOutput("a5_hold_vld", 32'(out_vld_o), 32'd1);
    checkOutput("a5_hold_dat", 32'(out_dat_o), 32'h0A5);
    checkFrame("a5");
    holdBits(1);

    $display("[TB] 9E2 0x1C3 good then bad parity");
    applyStimulus(9'h1C3, 9, 1, 0, 2, 1, -1);
    checkFrame("1c3_good");
    holdBits(1);
    applyStimulus(9'h1C3, 9, 1, 1, 2, 1, -1);
    checkFrame("1c3_bad");
    checkOutput("1c3_perr_model", 32'(exp_perr), 32'd1);
    holdBits(1);

    $display("[TB] 7N1 framing error then clean frame");
    applyStimulus(9'h055, 7, 0, 0, 1, 0, -1);
    checkFrame("ferr55");
    holdBits(1);
    applyStimulus(9'h02A, 7, 0, 0, 1, 1, -1);
    checkFrame("clean2a");
    holdBits(1);

    $display("[TB] overrun with output stalled");
    applyStimulus(9'h011, 8, 0, 0, 1, 1, -1);
    applyStimulus(9'h022, 8, 0, 0, 1, 1, -1);
    holdBits(2);
    checkOutput("ovr_vld", 32'(out_vld_o), 32'd1);
    checkOutput("ovr_dat", 32'(out_dat_o), 32'h011);
    checkOutput("ovr_flag", 32'(overrun_o), 32'd1);
    consume("ovr_consume");
    holdBits(2);
    checkOutput("ovr_empty", 32'(out_vld_o), 32'd0);

    $display("[TB] short glitch ignored");
    rx_i = 1'b0;
    repeat (30) @(negedge clk);
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_vld", 32'(out_vld_o), 32'd0);
    applyStimulus(9'h03C, 8, 0, 0, 1, 1, -1);
    checkFrame("after_glitch");
    holdBits(1);

    $display("[TB] receiver disabled mid-frame");
    applyStimulus(9'h0F0, 8, 0, 0, 1, 1, 4);
    holdBits(2);
    checkOutput("abort_vld", 32'(out_vld_o), 32'd0);
    checkOutput("abort_ovr_clear", 32'(overrun_o), 32'd0);
    applyStimulus(9'h081, 8, 0, 0, 1, 1, -1);
    checkFrame("after_abort");
    checkOutput("after_abort_ovr", 32'(overrun_o), 32'd0);
    holdBits(1);

    $display("[TB] break condition");
    internal_clk_divider = 8'd8;
    n_data_bits = 4'd8;
    n_parity_bits = 1'b0;
    n_stop_bits = 2'd1;
    rx_i = 1'b0;
    holdBits(12);
    checkOutput("break_vld", 32'(out_vld_o), 32'd1);
    checkOutput("break_dat", 32'(out_dat_o), 32'd0);
    checkOutput("break_ferr", 32'(frame_err_o), 32'd1);
    consume("break_consume");
    holdBits(4);
    rx_i = 1'b1;
    holdBits(4);
    checkOutput("break_single", 32'(out_vld_o), 32'd0);

    $display("[TB] randomized frames");
    for (int k = 0; k < 14; k++) begin
      internal_clk_divider = 8'($urandom_range(4, 12));
      applyStimulus(9'($urandom), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), -1);
      checkFrame("rand");
      holdBits(1);
    end
    checkOutput("rand_ovr", 32'(overrun_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
